id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 178 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and EX operand selection.
// Build option: define ID_EX_FORWARDING_EN to add EX/MEM and MEM/WB operand forwarding.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_wreg,
    input  logic [3:0]  id_aluop,
    input  logic        id_alusrc,
    input  logic        id_memread,
    input  logic        id_regwrite,
    input  logic        flush,
    input  logic        exmem_regwrite,
    input  logic        memwb_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] exmem_result,
    input  logic [31:0] memwb_result,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [31:0] ex_store_data,
    output logic [3:0]  ex_aluop,
    output logic [4:0]  ex_wreg,
    output logic        ex_memread,
    output logic        ex_regwrite
);

    logic        ex_valid_q,     ex_valid_d;
    logic [31:0] ex_rs_data_q,   ex_rs_data_d;
    logic [31:0] ex_rt_data_q,   ex_rt_data_d;
    logic [31:0] ex_imm_q,       ex_imm_d;
    logic [4:0]  ex_wreg_q,      ex_wreg_d;
    logic [3:0]  ex_aluop_q,     ex_aluop_d;
    logic        ex_alusrc_q,    ex_alusrc_d;
    logic        ex_memread_q,   ex_memread_d;
    logic        ex_regwrite_q,  ex_regwrite_d;
`ifdef ID_EX_FORWARDING_EN
    logic [4:0]  ex_rs_q,        ex_rs_d;
    logic [4:0]  ex_rt_q,        ex_rt_d;
`endif

    logic        load_use;
    logic        raw_hazard;
    logic        stall_int;
    logic        bubble;
    logic [31:0] rs_fwd;
    logic [31:0] rt_fwd;

    // A load in EX cannot supply its data until MEM/WB, so a dependent ID instruction waits.
    always_comb begin
        load_use = id_valid & ex_valid_q & ex_memread_q & (ex_wreg_q != 5'd0)
                 & ((ex_wreg_q == id_rs) | (ex_wreg_q == id_rt));
    end

`ifdef ID_EX_FORWARDING_EN
    always_comb begin
        raw_hazard = 1'b0;
    end
`else
    // Without forwarding any producer still in EX or EX/MEM blocks; MEM/WB is covered by
    // the write-through register file.
    always_comb begin
        raw_hazard = id_valid & (
              (ex_valid_q & ex_regwrite_q & (ex_wreg_q != 5'd0)
               & ((ex_wreg_q == id_rs) | (ex_wreg_q == id_rt)))
            | (exmem_regwrite & (exmem_rd != 5'd0)
               & ((exmem_rd == id_rs) | (exmem_rd == id_rt))));
    end
`endif

    // Flush wins over stall; reset also forces stall low while held.
    assign stall_int = rst_n & ~flush & (load_use | raw_hazard);
    assign bubble    = stall_int | flush;

    always_comb begin
        ex_valid_d    = id_valid & ~bubble;
        ex_memread_d  = id_memread & ~bubble;
        ex_regwrite_d = id_regwrite & ~bubble;
        ex_rs_data_d  = id_rs_data;
        ex_rt_data_d  = id_rt_data;
        ex_imm_d      = id_imm;
        ex_wreg_d     = id_wreg;
        ex_aluop_d    = id_aluop;
        ex_alusrc_d   = id_alusrc;
`ifdef ID_EX_FORWARDING_EN
        ex_rs_d       = id_rs;
        ex_rt_d       = id_rt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_rs_data_q  <= 32'd0;
            ex_rt_data_q  <= 32'd0;
            ex_imm_q      <= 32'd0;
            ex_wreg_q     <= 5'd0;
            ex_aluop_q    <= 4'd0;
            ex_alusrc_q   <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_regwrite_q <= 1'b0;
`ifdef ID_EX_FORWARDING_EN
            ex_rs_q       <= 5'd0;
            ex_rt_q       <= 5'd0;
`endif
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_rs_data_q  <= ex_rs_data_d;
            ex_rt_data_q  <= ex_rt_data_d;
            ex_imm_q      <= ex_imm_d;
            ex_wreg_q     <= ex_wreg_d;
            ex_aluop_q    <= ex_aluop_d;
            ex_alusrc_q   <= ex_alusrc_d;
            ex_memread_q  <= ex_memread_d;
            ex_regwrite_q <= ex_regwrite_d;
`ifdef ID_EX_FORWARDING_EN
            ex_rs_q       <= ex_rs_d;
            ex_rt_q       <= ex_rt_d;
`endif
        end
    end

`ifdef ID_EX_FORWARDING_EN
    // EX/MEM is the younger producer, so it takes priority over MEM/WB; r0 is never forwarded.
    always_comb begin
        rs_fwd = ex_rs_data_q;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == ex_rs_q)) begin
            rs_fwd = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == ex_rs_q)) begin
            rs_fwd = memwb_result;
        end
    end

    always_comb begin
        rt_fwd = ex_rt_data_q;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == ex_rt_q)) begin
            rt_fwd = exmem_result;
        end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == ex_rt_q)) begin
            rt_fwd = memwb_result;
        end
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{exmem_result, memwb_result, memwb_rd, memwb_regwrite};

    always_comb begin
        rs_fwd = ex_rs_data_q;
        rt_fwd = ex_rt_data_q;
    end
`endif

    // Operand buses are quiet whenever EX holds a bubble.
    always_comb begin
        alu_in1       = 32'd0;
        alu_in2       = 32'd0;
        ex_store_data = 32'd0;
        if (ex_valid_q) begin
            alu_in1       = rs_fwd;
            alu_in2       = ex_alusrc_q ? ex_imm_q : rt_fwd;
            ex_store_data = rt_fwd;
        end
    end

    assign stall       = stall_int;
    assign ex_valid    = ex_valid_q;
    assign ex_aluop    = ex_aluop_q;
    assign ex_wreg     = ex_wreg_q;
    assign ex_memread  = ex_memread_q;
    assign ex_regwrite = ex_regwrite_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage; expectations follow ID_EX_FORWARDING_EN when defined.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_wreg;
    logic [3:0]  id_aluop;
    logic        id_alusrc, id_memread, id_regwrite;
    logic        flush;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        stall, ex_valid;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [3:0]  ex_aluop;
    logic [4:0]  ex_wreg;
    logic        ex_memread, ex_regwrite;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_wreg(id_wreg), .id_aluop(id_aluop),
        .id_alusrc(id_alusrc), .id_memread(id_memread), .id_regwrite(id_regwrite),
        .flush(flush), .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .stall(stall), .ex_valid(ex_valid), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .ex_store_data(ex_store_data), .ex_aluop(ex_aluop), .ex_wreg(ex_wreg),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite)
    );

    typedef enum logic [3:0] {
        S_STALL, S_VALID, S_IN1, S_IN2, S_STORE, S_WREG, S_ALUOP, S_REGW, S_MEMR
    } sel_e;

    typedef struct packed {
        logic [31:0] cyc;
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(sel_e s);
        case (s)
            S_STALL: return {31'd0, stall};
            S_VALID: return {31'd0, ex_valid};
            S_IN1:   return alu_in1;
            S_IN2:   return alu_in2;
            S_STORE: return ex_store_data;
            S_WREG:  return {27'd0, ex_wreg};
            S_ALUOP: return {28'd0, ex_aluop};
            S_REGW:  return {31'd0, ex_regwrite};
            S_MEMR:  return {31'd0, ex_memread};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: every negedge, pop and compare all expectations queued for this cycle.
    exp_t        mon_e;
    logic [31:0] mon_got;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (mon_e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                         mon_e.sel.name(), mon_e.cyc, cyc);
            end else begin
                mon_got = observe(mon_e.sel);
                if (mon_got !== mon_e.val) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h",
                             mon_e.sel.name(), cyc, mon_got, mon_e.val);
                end
            end
        end
    end

    task automatic expect_sig(input sel_e s, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc;
        e.sel = s;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_ops(input logic v, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] st);
        expect_sig(S_VALID, {31'd0, v});
        expect_sig(S_IN1, a);
        expect_sig(S_IN2, b);
        expect_sig(S_STORE, st);
    endtask

    task automatic expect_bubble();
        expect_sig(S_VALID, 32'd0);
        expect_sig(S_REGW, 32'd0);
        expect_sig(S_MEMR, 32'd0);
        expect_sig(S_IN1, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] wr, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [3:0] op, input logic src,
                          input logic mr, input logic rw);
        id_valid = v; id_rs = rs; id_rt = rt; id_wreg = wr;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_aluop = op;
        id_alusrc = src; id_memread = mr; id_regwrite = rw;
    endtask

    task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mrw, input logic [4:0] mrd, input logic [31:0] mres);
        exmem_regwrite = erw; exmem_rd = erd; exmem_result = eres;
        memwb_regwrite = mrw; memwb_rd = mrd; memwb_result = mres;
    endtask

    task automatic clear_all();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        flush = 1'b0;
    endtask

    // Load word r8 <- mem[r1 + 0x10]
    task automatic issue_lw();
        set_id(1'b1, 5'd1, 5'd0, 5'd8, 32'h1000, 32'd0, 32'h10, 4'd2, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        clear_all();
        tick();

        // Reset held with a valid instruction and a matching EX/MEM producer in front of it.
        set_id(1'b1, 5'd5, 5'd5, 5'd5, 32'h1234, 32'h5678, 32'h9, 4'd7, 1'b0, 1'b1, 1'b1);
        set_fwd(1'b1, 5'd5, 32'h77, 1'b1, 5'd5, 32'h88);
        for (int i = 0; i < 3; i++) begin
            expect_ops(1'b0, 32'd0, 32'd0, 32'd0);
            expect_sig(S_STALL, 32'd0);
            expect_sig(S_MEMR, 32'd0);
            expect_sig(S_WREG, 32'd0);
            tick();
        end
        clear_all();
        rst_n = 1'b1;
        expect_sig(S_STALL, 32'd0);
        expect_sig(S_VALID, 32'd0);
        tick();

        // A: plain register-register op
        set_id(1'b1, 5'd1, 5'd2, 5'd4, 32'h100, 32'h200, 32'h30, 4'd3, 1'b0, 1'b0, 1'b1);
        expect_sig(S_STALL, 32'd0);
        tick();
        // B: immediate op, independent of A; A sits in EX/MEM
        set_id(1'b1, 5'd6, 5'd7, 5'd9, 32'h600, 32'h700, 32'h44, 4'd5, 1'b1, 1'b0, 1'b1);
        set_fwd(1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 32'd0);
        expect_ops(1'b1, 32'h100, 32'h200, 32'h200);
        expect_sig(S_WREG, 32'd4);
        expect_sig(S_ALUOP, 32'd3);
        expect_sig(S_REGW, 32'd1);
        expect_sig(S_MEMR, 32'd0);
        expect_sig(S_STALL, 32'd0);
        tick();
        // C: reads r9 produced by B (ALU op, not a load)
        set_id(1'b1, 5'd9, 5'd0, 5'd10, 32'h900, 32'd0, 32'd0, 4'd1, 1'b0, 1'b0, 1'b1);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        expect_ops(1'b1, 32'h600, 32'h44, 32'h700);
        expect_sig(S_ALUOP, 32'd5);
`ifdef ID_EX_FORWARDING_EN
        expect_sig(S_STALL, 32'd0);
        tick();
        id_valid = 1'b0;
        set_fwd(1'b1, 5'd9, 32'h999, 1'b0, 5'd0, 32'd0);
        expect_ops(1'b1, 32'h999, 32'd0, 32'd0);
        tick();
`else
        expect_sig(S_STALL, 32'd1);
        tick();
        set_fwd(1'b1, 5'd9, 32'h999, 1'b0, 5'd0, 32'd0);
        expect_bubble();
        expect_sig(S_STALL, 32'd1);
        tick();
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h999);
        id_rs_data = 32'h999;
        expect_bubble();
        expect_sig(S_STALL, 32'd0);
        tick();
        clear_all();
        expect_ops(1'b1, 32'h999, 32'd0, 32'd0);
        tick();
`endif

        // D: EX/MEM and MEM/WB both write r5; EX/MEM must win
        clear_all();
        set_id(1'b1, 5'd5, 5'd5, 5'd11, 32'h55, 32'h56, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_sig(S_STALL, 32'd0);
        tick();
        clear_all();
        set_fwd(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
`ifdef ID_EX_FORWARDING_EN
        expect_ops(1'b1, 32'h11, 32'h11, 32'h11);
`else
        expect_ops(1'b1, 32'h55, 32'h56, 32'h56);
`endif
        tick();
        // E: only MEM/WB enabled for r5
        clear_all();
        set_id(1'b1, 5'd5, 5'd12, 5'd13, 32'h57, 32'hC0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        clear_all();
        set_fwd(1'b0, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
`ifdef ID_EX_FORWARDING_EN
        expect_ops(1'b1, 32'h22, 32'hC0, 32'hC0);
`else
        expect_ops(1'b1, 32'h57, 32'hC0, 32'hC0);
`endif
        tick();

        // Load-use: lw r8 then consumer U reading r8
        clear_all();
        issue_lw();
        expect_sig(S_STALL, 32'd0);
        tick();
        set_id(1'b1, 5'd8, 5'd0, 5'd14, 32'h1111, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        expect_ops(1'b1, 32'h1000, 32'h10, 32'd0);
        expect_sig(S_MEMR, 32'd1);
        expect_sig(S_WREG, 32'd8);
        expect_sig(S_STALL, 32'd1);
        tick();
        set_fwd(1'b1, 5'd8, 32'h2000, 1'b0, 5'd0, 32'd0);
        expect_bubble();
`ifdef ID_EX_FORWARDING_EN
        expect_sig(S_STALL, 32'd0);
        tick();
        id_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hABCD);
        expect_ops(1'b1, 32'hABCD, 32'd0, 32'd0);
        expect_sig(S_STALL, 32'd0);
        tick();
`else
        expect_sig(S_STALL, 32'd1);
        tick();
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hABCD);
        id_rs_data = 32'hABCD;
        expect_bubble();
        expect_sig(S_STALL, 32'd0);
        tick();
        clear_all();
        expect_ops(1'b1, 32'hABCD, 32'd0, 32'd0);
        tick();
`endif

        // Flush in the same cycle as a load-use hazard
        clear_all();
        issue_lw();
        tick();
        set_id(1'b1, 5'd8, 5'd0, 5'd14, 32'h1111, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        expect_sig(S_STALL, 32'd0);
        tick();
        clear_all();
        expect_bubble();
        tick();

        // r0: load to r0 in EX and EX/MEM/MEM/WB writing r0 must be ignored
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd3, 32'h30, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        set_fwd(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE);
        expect_ops(1'b1, 32'd0, 32'd0, 32'd0);
        expect_sig(S_STALL, 32'd0);
        tick();
        set_id(1'b1, 5'd1, 5'd3, 5'd15, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        expect_sig(S_VALID, 32'd1);
        expect_sig(S_IN1, 32'h30);
`ifdef ID_EX_FORWARDING_EN
        expect_sig(S_STALL, 32'd0);
`else
        expect_sig(S_STALL, 32'd1);
`endif
        tick();
        clear_all();
        tick();

        // Reset asserted between clock edges while a load-use hazard is present
        issue_lw();
        tick();
        set_id(1'b1, 5'd8, 5'd0, 5'd14, 32'h8888, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        expect_ops(1'b0, 32'd0, 32'd0, 32'd0);
        expect_sig(S_STALL, 32'd0);
        expect_sig(S_MEMR, 32'd0);
        expect_sig(S_WREG, 32'd0);
        tick();
        expect_sig(S_VALID, 32'd0);
        expect_sig(S_STALL, 32'd0);
        tick();
        rst_n = 1'b1;
        expect_sig(S_VALID, 32'd0);
        expect_sig(S_STALL, 32'd0);
        tick();
        clear_all();
        expect_sig(S_VALID, 32'd1);
        expect_sig(S_IN1, 32'h8888);
        expect_sig(S_WREG, 32'd14);
        expect_sig(S_REGW, 32'd1);
        tick();

        // Drain: anything still queued was never compared
        for (int i = 0; i < 3 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
            checks += exp_q.size();
            errors += exp_q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
